// File: rtl/lake_sched_pkg.sv
// Shared defaults, the loop-dimension select width and the scheduler state type
// for the lakespec affine port controller.
package lake_sched_pkg;

    localparam int DEF_NUM_DIMS = 6;
    localparam int DEF_EXT_W    = 11;
    localparam int DEF_CYC_W    = 16;
    localparam int DEF_ADDR_W   = 9;
    localparam int DIM_SEL_W    = 3;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_RUN  = 2'd1,
        SCHED_DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/lake_for_loop.sv
// Iterator chain for an N-deep loop nest: picks the innermost dimension that can
// still advance, and steps it while zeroing every dimension inside it.
module lake_for_loop
    import lake_sched_pkg::*;
#(
    parameter int NUM_DIMS = DEF_NUM_DIMS,
    parameter int EXT_W    = DEF_EXT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_DIMS*EXT_W-1:0] extents,
    input  logic [DIM_SEL_W-1:0]      dimensionality,
    input  logic                      step,
    input  logic                      restart,
    output logic [DIM_SEL_W-1:0]      mux_sel,
    output logic                      last_iter
);

    logic [EXT_W-1:0] iters [NUM_DIMS];

    // Scan from outermost to innermost so the lowest eligible dimension wins.
    always_comb begin
        mux_sel   = '0;
        last_iter = 1'b1;
        for (int d = NUM_DIMS - 1; d >= 0; d--) begin
            if ((d < int'(dimensionality)) && (iters[d] != extents[d*EXT_W +: EXT_W])) begin
                mux_sel   = DIM_SEL_W'(d);
                last_iter = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            for (int d = 0; d < NUM_DIMS; d++) begin
                iters[d] <= '0;
            end
        end else if (step && !last_iter) begin
            for (int d = 0; d < NUM_DIMS; d++) begin
                if (d < int'(mux_sel)) begin
                    iters[d] <= '0;
                end else if (d == int'(mux_sel)) begin
                    iters[d] <= iters[d] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lake_affine_sched_ctrl.sv
// Affine schedule/address controller for one lakespec memory port: a free cycle
// counter is matched against an accumulated schedule to strobe the port.
module lake_affine_sched_ctrl
    import lake_sched_pkg::*;
#(
    parameter int NUM_DIMS = DEF_NUM_DIMS,
    parameter int EXT_W    = DEF_EXT_W,
    parameter int CYC_W    = DEF_CYC_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       stall,
    input  logic [DIM_SEL_W-1:0]       cfg_dimensionality,
    input  logic [NUM_DIMS*EXT_W-1:0]  cfg_extents,
    input  logic [CYC_W-1:0]           cfg_sched_offset,
    input  logic [NUM_DIMS*CYC_W-1:0]  cfg_sched_strides,
    input  logic [ADDR_W-1:0]          cfg_addr_offset,
    input  logic [NUM_DIMS*ADDR_W-1:0] cfg_addr_strides,
    output logic                       port_valid,
    output logic [ADDR_W-1:0]          port_addr,
    output logic [DIM_SEL_W-1:0]       mux_sel,
    output logic                       done
);

    sched_state_t         state, state_nxt;
    logic [CYC_W-1:0]     cyc;
    logic [CYC_W-1:0]     sched_cur;
    logic [ADDR_W-1:0]    addr_cur;
    logic [DIM_SEL_W-1:0] mux_sel_q;
    logic                 done_q;
    logic [DIM_SEL_W-1:0] dim_eff;
    logic [DIM_SEL_W-1:0] step_dim;
    logic                 last_iter;
    logic                 strobe;
    logic                 step;

    function automatic logic [CYC_W-1:0] sched_step(input logic [CYC_W-1:0] cur,
                                                    input logic [DIM_SEL_W-1:0] d);
        return cur + cfg_sched_strides[int'(d)*CYC_W +: CYC_W];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] cur,
                                                     input logic [DIM_SEL_W-1:0] d);
        return cur + cfg_addr_strides[int'(d)*ADDR_W +: ADDR_W];
    endfunction

    assign dim_eff = (cfg_dimensionality > DIM_SEL_W'(NUM_DIMS)) ? DIM_SEL_W'(NUM_DIMS)
                                                                 : cfg_dimensionality;
    assign step    = strobe && !last_iter;

    lake_for_loop #(
        .NUM_DIMS (NUM_DIMS),
        .EXT_W    (EXT_W)
    ) u_for_loop (
        .clk            (clk),
        .rst_n          (rst_n),
        .extents        (cfg_extents),
        .dimensionality (dim_eff),
        .step           (step),
        .restart        (flush),
        .mux_sel        (step_dim),
        .last_iter      (last_iter)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SCHED_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        strobe    = (state == SCHED_RUN) && !stall && !flush && (cyc == sched_cur);
        if (flush) begin
            state_nxt = (dim_eff != '0) ? SCHED_RUN : SCHED_IDLE;
        end else if (strobe && last_iter) begin
            state_nxt = SCHED_DONE;
        end
    end

    // The final strobe of the nest still fires; it only moves the FSM to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc       <= '0;
            sched_cur <= '0;
            addr_cur  <= '0;
            mux_sel_q <= '0;
            done_q    <= 1'b0;
        end else if (flush) begin
            cyc       <= '0;
            sched_cur <= cfg_sched_offset;
            addr_cur  <= cfg_addr_offset;
            mux_sel_q <= '0;
            done_q    <= 1'b0;
        end else if (!stall && (state == SCHED_RUN)) begin
            cyc <= cyc + 1'b1;
            if (strobe) begin
                if (last_iter) begin
                    done_q <= 1'b1;
                end else begin
                    sched_cur <= sched_step(sched_cur, step_dim);
                    addr_cur  <= addr_step(addr_cur, step_dim);
                    mux_sel_q <= step_dim;
                end
            end
        end
    end

    assign port_valid = strobe;
    assign port_addr  = addr_cur;
    assign mux_sel    = mux_sel_q;
    assign done       = done_q;

endmodule
